// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one bus cycle per valid/ready command,
// with a bus-side timeout and a valid/ready response port.
module wb_cmd_master #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic [7:0]  to_count
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic          cyc, cyc_n;
  logic          we_n;
  logic [3:0]    sel_n;
  logic [31:0]   adr_n, dat_n;
  logic          rv_n, re_n;
  logic [31:0]   rd_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0]    toc_n;

  assign cmd_ready = (state == IDLE) & ~rst;
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      timer     <= '0;
      to_count  <= '0;
    end else begin
      state     <= state_n;
      cyc       <= cyc_n;
      wbm_we_o  <= we_n;
      wbm_sel_o <= sel_n;
      wbm_adr_o <= adr_n;
      wbm_dat_o <= dat_n;
      rsp_valid <= rv_n;
      rsp_dat   <= rd_n;
      rsp_err   <= re_n;
      timer     <= timer_n;
      to_count  <= toc_n;
    end
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    we_n    = wbm_we_o;
    sel_n   = wbm_sel_o;
    adr_n   = wbm_adr_o;
    dat_n   = wbm_dat_o;
    rv_n    = rsp_valid;
    rd_n    = rsp_dat;
    re_n    = rsp_err;
    timer_n = timer;
    toc_n   = to_count;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          we_n    = cmd_we;
          sel_n   = cmd_sel;
          adr_n   = cmd_adr;
          dat_n   = cmd_dat;
          cyc_n   = 1'b1;
          timer_n = '0;
          state_n = BUS;
        end
      end
      BUS: begin
        // ack takes priority over an expiring timer on the same edge
        if (wbm_ack_i) begin
          cyc_n   = 1'b0;
          rd_n    = wbm_we_o ? 32'h0 : wbm_dat_i;
          re_n    = 1'b0;
          rv_n    = 1'b1;
          state_n = RESP;
        end else if (timer == TMAX) begin
          cyc_n   = 1'b0;
          rd_n    = 32'h0;
          re_n    = 1'b1;
          rv_n    = 1'b1;
          if (to_count != 8'hFF) toc_n = to_count + 8'd1;
          state_n = RESP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: BRAM-like slave with programmable ack delay,
// directed scenarios plus randomized commands against a memory model.
module tb_wb_cmd_master;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy;
  logic [7:0]  to_count;

  int n_vec = 0;
  int n_bad = 0;

  wb_cmd_master #(.TIMEOUT(TIMEOUT), .TW(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .busy(busy), .to_count(to_count)
  );

  always #5 clk = ~clk;

  // slave: acks in its dly-th strobe cycle (dly 0 = never)
  logic [31:0] smem [0:15];
  int  dly = 1;
  int  scnt = 0;
  int  stb_cnt = 0;
  logic stray = 1'b0;

  assign wbm_dat_i = smem[wbm_adr_o[5:2]];
  assign wbm_ack_i = stray |
    (wbm_stb_o && dly != 0 && scnt == dly - 1);

  always @(posedge clk) begin
    if (wbm_stb_o) stb_cnt <= stb_cnt + 1;
    if (wbm_stb_o && wbm_ack_i) begin
      scnt <= 0;
      if (wbm_we_o)
        for (int b = 0; b < 4; b++)
          if (wbm_sel_o[b])
            smem[wbm_adr_o[5:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
    end else if (wbm_stb_o) scnt <= scnt + 1;
    else scnt <= 0;
  end

  // reference model
  logic [31:0] ref_mem [logic [31:0]];
  int exp_to = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int d, input int hold);
    logic        e_err;
    logic [31:0] e_dat, m, d0;
    int          e_stb, n;
    e_err = (d == 0) || (d > TIMEOUT);
    e_stb = e_err ? TIMEOUT : d;
    e_dat = 32'h0;
    if (!e_err) begin
      if (we) begin
        m = ref_rd(adr);
        for (int b = 0; b < 4; b++)
          if (sel[b]) m[8*b +: 8] = dat[8*b +: 8];
        ref_mem[adr] = m;
      end else e_dat = ref_rd(adr);
    end else if (exp_to < 255) exp_to++;

    dly = d;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_adr = adr;
    cmd_dat = dat;
    cmd_sel = sel;
    stb_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("stb_after_accept", 32'(wbm_stb_o), 32'd1);
    check("cmd_ready_bus", 32'(cmd_ready), 32'd0);
    check("adr_o", wbm_adr_o, adr);
    check("we_o", 32'(wbm_we_o), 32'(we));
    check("sel_o", 32'(wbm_sel_o), 32'(sel));
    if (we) check("dat_o", wbm_dat_o, dat);

    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("stb_cycles", 32'(stb_cnt), 32'(e_stb));
    check("cyc_low_resp", 32'(wbm_cyc_o), 32'd0);
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_dat", rsp_dat, e_dat);
    check("to_count", 32'(to_count), 32'(exp_to));
    check("busy_resp", 32'(busy), 32'd1);

    d0 = rsp_dat;
    for (int i = 0; i < hold; i++) begin
      stray = (i == hold / 2);
      @(negedge clk);
      stray = 1'b0;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_dat", rsp_dat, d0);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_cyc", 32'(wbm_cyc_o), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", 32'(rsp_valid), 32'd0);
    check("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) smem[i] = 32'h0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_adr = '0;
    cmd_dat = '0;
    cmd_sel = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_to_count", 32'(to_count), 32'd0);
    check("rst_adr", wbm_adr_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    do_cmd(1'b1, 32'h3800_0010, 32'hA5A5_5A5A, 4'hF, 11, 0);
    do_cmd(1'b0, 32'h3800_0010, 32'h0, 4'hF, 3, 0);
    check("t2_read", rsp_dat, 32'hA5A5_5A5A);
    do_cmd(1'b1, 32'h3800_0010, 32'h1234_5678, 4'h3, 1, 0);
    do_cmd(1'b0, 32'h3800_0010, 32'h0, 4'hF, 2, 0);
    check("t2_merge", rsp_dat, 32'hA5A5_5678);

    do_cmd(1'b0, 32'h3800_0020, 32'h0, 4'hF, 0, 0);
    do_cmd(1'b1, 32'h3800_0020, 32'hDEAD_BEEF, 4'hF, TIMEOUT + 1, 0);
    do_cmd(1'b1, 32'h3800_0024, 32'hCAFE_F00D, 4'hF, TIMEOUT, 0);
    do_cmd(1'b0, 32'h3800_0024, 32'h0, 4'hF, TIMEOUT, 0);
    do_cmd(1'b0, 32'h3800_0010, 32'h0, 4'hF, 4, 20);

    // reset pulse in the middle of a hung cycle
    dly = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_adr = 32'h3800_0004;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_stb", 32'(wbm_stb_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_to = 0;
    check("mid_rst_stb", 32'(wbm_stb_o), 32'd0);
    check("mid_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("mid_rst_to_count", 32'(to_count), 32'd0);
    @(negedge clk);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    do_cmd(1'b0, 32'h3800_0010, 32'h0, 4'hF, 5, 1);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      int d;
      a = 32'h3800_0000 | (32'($urandom_range(0, 15)) << 2);
      n = $urandom_range(0, 19);
      d = (n == 0) ? 0 : (n == 1) ? TIMEOUT : $urandom_range(1, 12);
      do_cmd(1'($urandom), a, $urandom, 4'($urandom),
             d, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
